uart_tx_cmd: RTL and testbench

Command-frame transmitter for the UART link to the host. On a start pulse it latches the parameter set (mode, distance, phase offset, exposure time, laser width) and emits one 22-byte frame, byte by byte, to the byte-level uart_tx module. It is the sending end of the same frame format the board's UART command receiver decodes: header 0xAA, ID, reserved bytes, little-endian fields, spare byte, XOR checksum.

---
 rtl/uart_tx_cmd.sv | 154 +++++++++++++++
 tb/tb_uart_tx_cmd.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_cmd.sv
// Command-frame transmitter: latches the parameter set on start and feeds one
// 22-byte frame (header, ID, pads, LE fields, spare, XOR checksum) to uart_tx.
module uart_tx_cmd #(
  parameter logic [7:0]  FRAME_ID = 8'h02,
  parameter logic [7:0]  PAD_BYTE = 8'h00,
  parameter int unsigned BYTE_GAP = 0
) (
  input  logic        clk50M,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  mode,
  input  logic [15:0] distance,
  input  logic [31:0] phase_diff,
  input  logic [31:0] expose_time,
  input  logic [15:0] laser_width,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  input  logic        tx_done,
  output logic        busy,
  output logic        frame_done
);

  // state | meaning
  // IDLE  | waiting for start, checksum held at 8'hFF
  // SEND  | tx_en strobe for byte[idx]
  // WAIT  | holding tx_data until uart_tx reports tx_done
  // GAP   | inter-byte idle, down-counting BYTE_GAP cycles
  // DONE  | frame_done strobe, then back to IDLE
  typedef enum logic [2:0] {IDLE, SEND, WAIT, GAP, DONE} state_t;

  localparam logic [7:0] GAP_LOAD = (BYTE_GAP > 0) ? 8'(BYTE_GAP - 1) : 8'd0;

  state_t      state, state_nxt;
  logic [4:0]  idx;
  logic [4:0]  idx_sel;
  logic [7:0]  csum;
  logic [7:0]  gap_cnt;
  logic [7:0]  byte_nxt;
  logic [7:0]  mode_q;
  logic [15:0] distance_q;
  logic [31:0] phase_q;
  logic [31:0] expose_q;
  logic [15:0] width_q;

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    tx_en      = 1'b0;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = SEND;
      SEND: begin
        tx_en     = 1'b1;
        busy      = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        if (tx_done) begin
          if (idx == 5'd22)       state_nxt = DONE;
          else if (BYTE_GAP == 0) state_nxt = SEND;
          else                    state_nxt = GAP;
        end
      end
      GAP: begin
        busy = 1'b1;
        if (gap_cnt == 8'd0) state_nxt = SEND;
      end
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // In WAIT the byte being prepared is the one after the current index
  assign idx_sel = (state == WAIT) ? idx + 5'd1 : idx;

  always_comb begin
    byte_nxt = PAD_BYTE;
    case (idx_sel)
      5'd1:  byte_nxt = 8'hAA;
      5'd2:  byte_nxt = FRAME_ID;
      5'd8:  byte_nxt = mode_q;
      5'd9:  byte_nxt = distance_q[7:0];
      5'd10: byte_nxt = distance_q[15:8];
      5'd11: byte_nxt = phase_q[7:0];
      5'd12: byte_nxt = phase_q[15:8];
      5'd13: byte_nxt = phase_q[23:16];
      5'd14: byte_nxt = phase_q[31:24];
      5'd15: byte_nxt = expose_q[7:0];
      5'd16: byte_nxt = expose_q[15:8];
      5'd17: byte_nxt = expose_q[23:16];
      5'd18: byte_nxt = expose_q[31:24];
      5'd19: byte_nxt = width_q[7:0];
      5'd20: byte_nxt = width_q[15:8];
      5'd22: byte_nxt = csum;
      default: byte_nxt = PAD_BYTE;
    endcase
  end

  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      tx_data    <= 8'd0;
      idx        <= 5'd0;
      csum       <= 8'hFF;
      gap_cnt    <= 8'd0;
      mode_q     <= 8'd0;
      distance_q <= 16'd0;
      phase_q    <= 32'd0;
      expose_q   <= 32'd0;
      width_q    <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          csum <= 8'hFF;
          if (start) begin
            mode_q     <= mode;
            distance_q <= distance;
            phase_q    <= phase_diff;
            expose_q   <= expose_time;
            width_q    <= laser_width;
            idx        <= 5'd1;
            tx_data    <= 8'hAA;
          end
        end
        SEND: begin
          // Header and the checksum byte itself stay out of the XOR
          if (idx >= 5'd2 && idx <= 5'd21) csum <= csum ^ tx_data;
        end
        WAIT: begin
          if (tx_done && idx != 5'd22) begin
            idx <= idx + 5'd1;
            if (BYTE_GAP == 0) tx_data <= byte_nxt;
            else               gap_cnt <= GAP_LOAD;
          end
        end
        GAP: begin
          if (gap_cnt == 8'd0) tx_data <= byte_nxt;
          else                 gap_cnt <= gap_cnt - 8'd1;
        end
        DONE: idx <= 5'd0;
        default: idx <= 5'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cmd.sv
// Bench for uart_tx_cmd: two instances (BYTE_GAP 0 and 5), a uart_tx responder
// and a frame reference model built from the field layout.
module tb_uart_tx_cmd;

  logic clk50M = 1'b0;
  always #10 clk50M = ~clk50M;

  logic        rst_n;
  logic        start0, start5, tx_done0, tx_done5;
  logic [7:0]  mode;
  logic [15:0] distance, laser_width;
  logic [31:0] phase_diff, expose_time;
  logic [7:0]  tx_data0, tx_data5;
  logic        tx_en0, tx_en5, busy0, busy5, frame_done0, frame_done5;

  uart_tx_cmd #(.BYTE_GAP(0)) dut0 (
    .clk50M(clk50M), .rst_n(rst_n), .start(start0), .mode(mode), .distance(distance),
    .phase_diff(phase_diff), .expose_time(expose_time), .laser_width(laser_width),
    .tx_data(tx_data0), .tx_en(tx_en0), .tx_done(tx_done0), .busy(busy0),
    .frame_done(frame_done0));

  uart_tx_cmd #(.BYTE_GAP(5)) dut5 (
    .clk50M(clk50M), .rst_n(rst_n), .start(start5), .mode(mode), .distance(distance),
    .phase_diff(phase_diff), .expose_time(expose_time), .laser_width(laser_width),
    .tx_data(tx_data5), .tx_en(tx_en5), .tx_done(tx_done5), .busy(busy5),
    .frame_done(frame_done5));

  bit         sel;
  logic [7:0] o_data;
  logic       o_en, o_busy, o_fd;
  assign o_data = sel ? tx_data5 : tx_data0;
  assign o_en   = sel ? tx_en5 : tx_en0;
  assign o_busy = sel ? busy5 : busy0;
  assign o_fd   = sel ? frame_done5 : frame_done0;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_frame [22];
  logic [7:0] last_byte;
  logic [7:0] nominal [22] = '{8'hAA, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10,
                               8'h34, 8'h12, 8'h0D, 8'h0C, 8'h0B, 8'h0A, 8'h64, 8'h00,
                               8'h00, 8'h00, 8'h32, 8'h00, 8'h00, 8'h9D};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start5 = v; else start0 = v;
  endtask

  task automatic set_done(input logic v);
    if (sel) tx_done5 = v; else tx_done0 = v;
  endtask

  task automatic build_exp();
    logic [7:0] cs;
    exp_frame[0] = 8'hAA;
    exp_frame[1] = 8'h02;
    for (int i = 2; i < 7; i++) exp_frame[i] = 8'h00;
    exp_frame[7] = mode;
    exp_frame[8] = distance[7:0];
    exp_frame[9] = distance[15:8];
    for (int i = 0; i < 4; i++) begin
      exp_frame[10+i] = 8'(phase_diff >> (8*i));
      exp_frame[14+i] = 8'(expose_time >> (8*i));
    end
    exp_frame[18] = laser_width[7:0];
    exp_frame[19] = laser_width[15:8];
    exp_frame[20] = 8'h00;
    cs = 8'hFF;
    for (int i = 1; i <= 20; i++) cs = cs ^ exp_frame[i];
    exp_frame[21] = cs;
  endtask

  task automatic rand_fields();
    mode        = 8'($urandom);
    distance    = 16'($urandom);
    phase_diff  = $urandom;
    expose_time = $urandom;
    laser_width = 16'($urandom);
  endtask

  // Drives one start and plays the uart_tx side (tx_done 10 cycles after tx_en).
  task automatic run_frame(input bit s, input int gap, input bit perturb,
                           input bit spurious, input int abort_byte, input string tag);
    int n = 0;
    int done_t = -100;
    int en_t = -100;
    int resp_at = -1;
    bit fin = 1'b0;
    sel = s;
    @(negedge clk50M);
    set_start(1'b1);
    for (int t = 1; t < 4000 && !fin; t++) begin
      @(negedge clk50M);
      if (o_en) begin
        if (n < 22) chk($sformatf("%s byte%0d", tag, n + 1), o_data, exp_frame[n]);
        if (n == 0) chk($sformatf("%s start_lat", tag), t, 1);
        else        chk($sformatf("%s gap%0d", tag, n + 1), t - done_t, gap + 1);
        last_byte = o_data;
        n++;
        en_t = t;
        resp_at = t + 10;
      end
      if (o_fd) begin
        chk($sformatf("%s tx_en_count", tag), n, 22);
        chk($sformatf("%s busy_at_done", tag), o_busy, 0);
        fin = 1'b1;
      end else if (!fin) begin
        chk($sformatf("%s busy", tag), o_busy, 1);
      end
      if (abort_byte > 0 && n == abort_byte && t == en_t + 3) begin
        set_start(1'b0);
        set_done(1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort outputs", {o_data, o_en, o_busy, o_fd}, 0);
        repeat (20) begin
          @(negedge clk50M);
          chk("abort no_done", {o_fd, o_en}, 0);
        end
        rst_n = 1'b1;
        fin = 1'b1;
      end else begin
        if (t == resp_at) done_t = t;
        set_done((t == resp_at) || (spurious && t == done_t + 2));
        if (perturb && !fin) begin
          rand_fields();
          set_start(1'($urandom));
        end else begin
          set_start(1'b0);
        end
      end
    end
    chk($sformatf("%s completed", tag), fin, 1);
    set_done(1'b0);
    set_start(1'b0);
  endtask

  task automatic idle_chk(input int cycles, input string tag);
    repeat (cycles) begin
      @(negedge clk50M);
      chk(tag, {o_en, o_busy, o_fd}, 0);
    end
  endtask

  initial begin
    int en_cnt;
    rst_n = 1'b0;
    start0 = 0; start5 = 0; tx_done0 = 0; tx_done5 = 0; sel = 0;
    mode = 0; distance = 0; phase_diff = 0; expose_time = 0; laser_width = 0;
    #5;
    chk("reset dut0", {tx_data0, tx_en0, busy0, frame_done0}, 0);
    chk("reset dut5", {tx_data5, tx_en5, busy5, frame_done5}, 0);
    @(negedge clk50M); @(negedge clk50M);
    rst_n = 1'b1;

    repeat (100) begin
      @(negedge clk50M);
      chk("idle", {o_data, o_en, o_busy, o_fd}, 0);
    end

    // start without any tx_done: one byte, then stuck waiting
    start0 = 1'b1;
    @(negedge clk50M);
    start0 = 1'b0;
    en_cnt = 0;
    repeat (100) begin
      if (tx_en0) en_cnt++;
      chk("noresp busy", busy0, 1);
      @(negedge clk50M);
    end
    chk("noresp tx_en_count", en_cnt, 1);
    rst_n = 1'b0;
    @(negedge clk50M);
    rst_n = 1'b1;

    mode = 8'h10; distance = 16'h1234; phase_diff = 32'h0A0B0C0D;
    expose_time = 32'h00000064; laser_width = 16'h0032;
    for (int i = 0; i < 22; i++) exp_frame[i] = nominal[i];
    run_frame(0, 0, 0, 0, 0, "nominal");

    mode = 0; distance = 0; phase_diff = 0; expose_time = 0; laser_width = 0;
    build_exp();
    run_frame(0, 0, 0, 0, 0, "zero");
    chk("zero checksum", last_byte, 8'hFD);
    run_frame(0, 0, 0, 0, 0, "zero b2b");
    chk("zero b2b checksum", last_byte, 8'hFD);
    idle_chk(20, "after b2b");

    for (int k = 0; k < 3; k++) begin
      rand_fields();
      build_exp();
      run_frame(0, 0, 1, 0, 0, $sformatf("perturb%0d", k));
      idle_chk(30, "no second frame");
    end

    rand_fields();
    build_exp();
    run_frame(1, 5, 0, 1, 0, "gap5");
    idle_chk(20, "gap5 idle");

    mode = 8'h10; distance = 16'h1234; phase_diff = 32'h0A0B0C0D;
    expose_time = 32'h00000064; laser_width = 16'h0032;
    build_exp();
    run_frame(0, 0, 0, 0, 12, "abort");
    rand_fields();
    build_exp();
    run_frame(0, 0, 0, 0, 0, "post_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
